id_scoreboard: RTL and testbench

Register scoreboard and issue controller for the decode stage. It tracks outstanding register writes between ID issue and writeback, and detects read-after-write and write-count-overflow hazards on the operands ID requests from the regfile. It drives the ID/IF stall and the issue strobe to EX, and sits beside ID, consuming the same rs1/rs2/rd enables and addresses ID presents to the regfile.

---
 rtl/id_scoreboard.sv | 149 ++++++++++++++
 tb/tb_id_scoreboard.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register outstanding-write scoreboard and issue control
// for the decode stage. Tracks writes in flight between ID issue and
// writeback, and raises RAW / write-count-overflow hazards on ID operands.
module id_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic        id_r1_enable_i,
    input  logic        id_r2_enable_i,
    input  logic [4:0]  id_r1_addr_i,
    input  logic [4:0]  id_r2_addr_i,
    input  logic        id_w_enable_i,
    input  logic [4:0]  id_w_addr_i,
    input  logic        ex_ready_i,
    input  logic        flush_i,
    input  logic        wb_enable_i,
    input  logic [4:0]  wb_addr_i,
    output logic        id_issue_o,
    output logic        stall_id_o,
    output logic        stall_if_o,
    output logic [31:0] busy_o,
    output logic [31:0] stall_cycles_o,
    output logic        error_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 exists only to keep indexing uniform; it is held at zero.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [CNT_W-1:0] eff   [32];

    logic [31:0] wb_sel;
    logic [31:0] wr_sel;

    logic        r1_haz;
    logic        r2_haz;
    logic        w_haz;
    logic        hazard;
    logic        issue;
    logic        stall;

    logic        err_q;
    logic        err_d;
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    // One-hot select of the register retired by writeback this cycle (x0 never selected)
    always_comb begin
        wb_sel = '0;
        if (wb_enable_i) begin
            wb_sel[wb_addr_i] = 1'b1;
        end
        wb_sel[0] = 1'b0;
    end

    // Effective counts: a same-cycle writeback already satisfies a read (write-first regfile)
    always_comb begin
        eff[0] = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            if (wb_sel[i] && (cnt_q[i] != '0)) begin
                eff[i] = cnt_q[i] - CNT_ONE;
            end else begin
                eff[i] = cnt_q[i];
            end
        end
    end

    // Hazard detection on the operands and destination ID presents
    always_comb begin
        r1_haz = id_r1_enable_i && (id_r1_addr_i != 5'd0) && (eff[id_r1_addr_i] != '0);
        r2_haz = id_r2_enable_i && (id_r2_addr_i != 5'd0) && (eff[id_r2_addr_i] != '0);
        w_haz  = id_w_enable_i  && (id_w_addr_i  != 5'd0) && (eff[id_w_addr_i]  == CNT_MAX);
        hazard = id_valid_i && (r1_haz || r2_haz || w_haz);
    end

    // Issue / stall decisions; reset forces both low, flush suppresses both
    always_comb begin
        issue = rst && id_valid_i && !flush_i && !hazard && ex_ready_i;
        stall = rst && id_valid_i && !flush_i && !issue;
    end

    assign id_issue_o = issue;
    assign stall_id_o = stall;
    assign stall_if_o = stall;

    // One-hot select of the destination counted by an issuing instruction
    always_comb begin
        wr_sel = '0;
        if (issue && id_w_enable_i) begin
            wr_sel[id_w_addr_i] = 1'b1;
        end
        wr_sel[0] = 1'b0;
    end

    // Next-state for counters; decrement only when the count is non-zero
    always_comb begin
        cnt_d[0] = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            case ({wr_sel[i], wb_sel[i] && (cnt_q[i] != '0)})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_ONE;
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // Sticky error on writeback with nothing outstanding; hazard stall counter
    always_comb begin
        err_d = err_q;
        if (wb_enable_i && (wb_addr_i != 5'd0) && (cnt_q[wb_addr_i] == '0)) begin
            err_d = 1'b1;
        end
        stall_cnt_d = stall_cnt_q + {31'd0, stall && hazard};
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Busy vector derived from the registered counts
    always_comb begin
        busy_o = '0;
        for (int unsigned i = 1; i < 32; i++) begin
            busy_o[i] = (cnt_q[i] != '0);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign error_o        = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Testbench for id_scoreboard: directed vector table plus randomized traffic,
// both checked against a count-per-register reference model.
module tb_id_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i, id_r1_enable_i, id_r2_enable_i;
    logic [4:0]  id_r1_addr_i, id_r2_addr_i;
    logic        id_w_enable_i;
    logic [4:0]  id_w_addr_i;
    logic        ex_ready_i, flush_i, wb_enable_i;
    logic [4:0]  wb_addr_i;
    logic        id_issue_o, stall_id_o, stall_if_o, error_o;
    logic [31:0] busy_o, stall_cycles_o;

    always #5 clk = ~clk;

    id_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_r1_enable_i (id_r1_enable_i),
        .id_r2_enable_i (id_r2_enable_i),
        .id_r1_addr_i   (id_r1_addr_i),
        .id_r2_addr_i   (id_r2_addr_i),
        .id_w_enable_i  (id_w_enable_i),
        .id_w_addr_i    (id_w_addr_i),
        .ex_ready_i     (ex_ready_i),
        .flush_i        (flush_i),
        .wb_enable_i    (wb_enable_i),
        .wb_addr_i      (wb_addr_i),
        .id_issue_o     (id_issue_o),
        .stall_id_o     (stall_id_o),
        .stall_if_o     (stall_if_o),
        .busy_o         (busy_o),
        .stall_cycles_o (stall_cycles_o),
        .error_o        (error_o)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: plain outstanding-write counts per register
    int          m_cnt [32];
    bit          m_err;
    logic [31:0] m_sc;

    typedef struct {
        bit          rst, valid, r1en;
        logic [4:0]  r1;
        bit          r2en;
        logic [4:0]  r2;
        bit          wen;
        logic [4:0]  wa;
        bit          exr, flush, wben;
        logic [4:0]  wba;
        bit          e_issue, e_stall;
        logic [31:0] e_busy, e_sc;
        bit          e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rs, bit v, bit r1en, int r1, bit r2en, int r2,
                                bit wen, int wa, bit exr, bit fl, bit wben, int wba,
                                bit ei, bit es, logic [31:0] eb, int esc, bit ee);
        vec_t t;
        t.rst = rs; t.valid = v; t.r1en = r1en; t.r1 = 5'(r1); t.r2en = r2en; t.r2 = 5'(r2);
        t.wen = wen; t.wa = 5'(wa); t.exr = exr; t.flush = fl; t.wben = wben; t.wba = 5'(wba);
        t.e_issue = ei; t.e_stall = es; t.e_busy = eb; t.e_sc = 32'(esc); t.e_err = ee;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst; id_valid_i = v.valid;
        id_r1_enable_i = v.r1en; id_r1_addr_i = v.r1;
        id_r2_enable_i = v.r2en; id_r2_addr_i = v.r2;
        id_w_enable_i = v.wen; id_w_addr_i = v.wa;
        ex_ready_i = v.exr; flush_i = v.flush;
        wb_enable_i = v.wben; wb_addr_i = v.wba;
    endtask

    function automatic int m_eff(int i);
        if (wb_enable_i && int'(wb_addr_i) == i && m_cnt[i] > 0) return m_cnt[i] - 1;
        return m_cnt[i];
    endfunction

    // Compare all outputs with the model for the current inputs, then advance one clock
    task automatic model_step();
        bit haz, iss, stl;
        logic [31:0] busy;
        int pre;
        haz = id_valid_i && (
              (id_r1_enable_i && id_r1_addr_i != 0 && m_eff(int'(id_r1_addr_i)) != 0) ||
              (id_r2_enable_i && id_r2_addr_i != 0 && m_eff(int'(id_r2_addr_i)) != 0) ||
              (id_w_enable_i  && id_w_addr_i  != 0 && m_eff(int'(id_w_addr_i)) == MAXV));
        iss = rst && id_valid_i && !flush_i && !haz && ex_ready_i;
        stl = rst && id_valid_i && !flush_i && !iss;
        busy = '0;
        for (int i = 1; i < 32; i++) busy[i] = (m_cnt[i] != 0);
        check("model_issue", 64'(id_issue_o), 64'(iss));
        check("model_stall_id", 64'(stall_id_o), 64'(stl));
        check("model_stall_if", 64'(stall_if_o), 64'(stl));
        check("model_busy", 64'(busy_o), 64'(busy));
        check("model_stall_cycles", 64'(stall_cycles_o), 64'(m_sc));
        check("model_error", 64'(error_o), 64'(m_err));
        @(posedge clk);
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_err = 0;
            m_sc  = '0;
        end else begin
            if (wb_enable_i && wb_addr_i != 0) begin
                pre = m_cnt[wb_addr_i];
                if (pre > 0) m_cnt[wb_addr_i] = pre - 1;
                else         m_err = 1;
            end
            if (iss && id_w_enable_i && id_w_addr_i != 0) m_cnt[id_w_addr_i]++;
            if (stl && haz) m_sc = m_sc + 32'd1;
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] B5  = 32'h1 << 5;
    localparam logic [31:0] B6  = 32'h1 << 6;
    localparam logic [31:0] B7  = 32'h1 << 7;
    localparam logic [31:0] B9  = 32'h1 << 9;
    localparam logic [31:0] B10 = 32'h1 << 10;
    localparam logic [31:0] B12 = 32'h1 << 12;

    initial begin
        vec_t v;
        // rst v r1en r1 r2en r2 wen wa exr fl wben wba | issue stall busy sc err
        // RAW on x5, released by same-cycle writeback
        vecs.push_back(mk(1,1,0,0,0,0,1,5,1,0,0,0, 1,0,0,  0,0));
        vecs.push_back(mk(1,1,1,5,0,0,1,6,1,0,0,0, 0,1,B5, 0,0));
        vecs.push_back(mk(1,1,1,5,0,0,1,6,1,0,0,0, 0,1,B5, 1,0));
        vecs.push_back(mk(1,1,1,5,0,0,1,6,1,0,1,5, 1,0,B5, 2,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,B6, 2,0));
        // x0 is never tracked
        vecs.push_back(mk(1,1,0,0,0,0,1,0,1,0,0,0, 1,0,B6, 2,0));
        vecs.push_back(mk(1,1,1,0,1,0,0,0,1,0,0,0, 1,0,B6, 2,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 0,0,B6, 2,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,6, 0,0,B6, 2,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  2,0));
        // WAW saturation on x7
        vecs.push_back(mk(1,1,0,0,0,0,1,7,1,0,0,0, 1,0,0,  2,0));
        vecs.push_back(mk(1,1,0,0,0,0,1,7,1,0,0,0, 1,0,B7, 2,0));
        vecs.push_back(mk(1,1,0,0,0,0,1,7,1,0,0,0, 1,0,B7, 2,0));
        vecs.push_back(mk(1,1,0,0,0,0,1,7,1,0,0,0, 0,1,B7, 2,0));
        vecs.push_back(mk(1,1,0,0,0,0,1,7,1,0,1,7, 1,0,B7, 3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,7, 0,0,B7, 3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,7, 0,0,B7, 3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,7, 0,0,B7, 3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  3,0));
        // simultaneous issue and writeback on x9
        vecs.push_back(mk(1,1,0,0,0,0,1,9,1,0,0,0, 1,0,0,  3,0));
        vecs.push_back(mk(1,1,0,0,0,0,1,9,1,0,1,9, 1,0,B9, 3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,9, 0,0,B9, 3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  3,0));
        // underflow error, flush, back-pressure
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,3, 0,0,0,  3,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  3,1));
        vecs.push_back(mk(1,1,0,0,0,0,1,10,1,0,0,0, 1,0,0, 3,1));
        vecs.push_back(mk(1,1,1,10,0,0,0,0,1,1,0,0, 0,0,B10,3,1));
        vecs.push_back(mk(1,1,1,10,0,0,1,11,1,1,0,0,0,0,B10,3,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,B10,3,1));
        vecs.push_back(mk(1,1,1,10,0,0,0,0,0,0,0,0, 0,1,B10,3,1));
        vecs.push_back(mk(1,1,1,11,0,0,0,0,0,0,0,0, 0,1,B10,4,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,B10,4,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,10,0,0,B10,4,1));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  4,1));
        // reset mid-operation with a hazard present, then stale writeback
        vecs.push_back(mk(1,1,0,0,0,0,1,12,1,0,0,0, 1,0,0, 4,1));
        vecs.push_back(mk(0,1,1,12,0,0,0,0,1,0,0,0, 0,0,B12,4,1));
        vecs.push_back(mk(0,1,1,12,0,0,0,0,1,0,0,0, 0,0,0, 0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,12,0,0,0,  0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,  0,1));

        // initial reset
        v = mk(0,1,1,1,1,2,1,3,1,0,0,0, 0,0,0,0,0);
        drive(v);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 0;
        m_sc  = '0;
        @(negedge clk);
        #1;
        check("reset_issue", 64'(id_issue_o), 64'(0));
        check("reset_stall", 64'(stall_id_o), 64'(0));
        @(negedge clk);

        // directed table
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            #1;
            check($sformatf("vec%0d_issue", k), 64'(id_issue_o), 64'(vecs[k].e_issue));
            check($sformatf("vec%0d_stall_id", k), 64'(stall_id_o), 64'(vecs[k].e_stall));
            check($sformatf("vec%0d_stall_if", k), 64'(stall_if_o), 64'(vecs[k].e_stall));
            check($sformatf("vec%0d_busy", k), 64'(busy_o), 64'(vecs[k].e_busy));
            check($sformatf("vec%0d_stall_cycles", k), 64'(stall_cycles_o), 64'(vecs[k].e_sc));
            check($sformatf("vec%0d_error", k), 64'(error_o), 64'(vecs[k].e_err));
            model_step();
        end

        // randomized traffic on a small register window to provoke hazards
        for (int k = 0; k < 3000; k++) begin
            v.rst   = ($urandom_range(0, 199) != 0);
            v.valid = ($urandom_range(0, 3) != 0);
            v.r1en  = $urandom_range(0, 1);
            v.r1    = 5'($urandom_range(0, 7));
            v.r2en  = $urandom_range(0, 1);
            v.r2    = 5'($urandom_range(0, 7));
            v.wen   = ($urandom_range(0, 3) != 0);
            v.wa    = 5'($urandom_range(0, 7));
            v.exr   = ($urandom_range(0, 3) != 0);
            v.flush = ($urandom_range(0, 7) == 0);
            v.wben  = ($urandom_range(0, 1) != 0);
            v.wba   = 5'($urandom_range(0, 7));
            drive(v);
            #1;
            model_step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
